// File: rtl/calc_display_pkg.sv
// Shared types and seven-segment constants for the calculator display path.
// Segment bytes are active-high: bit 7 = dot, bits 6..0 = segments g..a.
package calc_display_pkg;

  typedef enum logic [0:0] {
    StBlank,
    StDrive
  } state_e;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  localparam logic [7:0] D_0     = 8'h3F;
  localparam logic [7:0] D_1     = 8'h06;
  localparam logic [7:0] D_2     = 8'h5B;
  localparam logic [7:0] D_3     = 8'h4F;
  localparam logic [7:0] D_4     = 8'h66;
  localparam logic [7:0] D_5     = 8'h6D;
  localparam logic [7:0] D_6     = 8'h7D;
  localparam logic [7:0] D_7     = 8'h07;
  localparam logic [7:0] D_8     = 8'h7F;
  localparam logic [7:0] D_9     = 8'h6F;
  localparam logic [7:0] D_A     = 8'h77;
  localparam logic [7:0] D_B     = 8'h7C;
  localparam logic [7:0] D_C     = 8'h39;
  localparam logic [7:0] D_D     = 8'h5E;
  localparam logic [7:0] D_E     = 8'h79;
  localparam logic [7:0] D_F     = 8'h71;
  localparam logic [7:0] D_DOT   = 8'h80;
  localparam logic [7:0] D_R     = 8'h50;
  localparam logic [7:0] D_O     = 8'h5C;
  localparam logic [7:0] D_MINUS = 8'h40;
  localparam logic [7:0] D_EMPTY = 8'h00;

endpackage

// File: rtl/display_mux_if.sv
// Frame handshake between the calculator core (master) and the display scanner (slave).
interface display_mux_if #(
  parameter int unsigned DIGITS = 8
);

  logic [8*DIGITS-1:0] frame_data;
  logic                frame_valid;
  logic                frame_ready;

  modport master (
    output frame_data,
    output frame_valid,
    input  frame_ready
  );

  modport slave (
    input  frame_data,
    input  frame_valid,
    output frame_ready
  );

endinterface

// File: rtl/digit_timer.sv
// Loadable down-counter with terminal-count flag; tc_next anticipates the next cycle's flag
// so the scanner can register outputs that depend on it.
module digit_timer #(
  parameter int unsigned     Width      = 4,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [Width-1:0] load_value,
  output logic             tc,
  output logic             tc_next
);

  logic [Width-1:0] count_q, count_d;

  // Load has priority; otherwise count down and hold at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= ResetValue;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc      = (count_q == '0);
  assign tc_next = (count_d == '0);

endmodule

// File: rtl/display_mux.sv
// Double-buffered, time-multiplexed driver for a multi-digit seven-segment display.
// Accepts whole frames over a valid/ready handshake and scans them out one digit at a time
// with a blanking gap; all outputs are registered from next-state values.
module display_mux
  import calc_display_pkg::*;
#(
  parameter int unsigned DIGITS       = 8,
  parameter int unsigned DIGIT_CYCLES = 1024,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic              clock,
  input  logic              reset,
  display_mux_if.slave      bus,
  output logic [7:0]        display_leds,
  output logic [DIGITS-1:0] display_control,
  output logic              frame_done
);

  localparam int unsigned IdxW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned MaxCycles = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  localparam logic [CntW-1:0] DriveLoad  = CntW'(DIGIT_CYCLES - 1);
  // With no blanking gap the timer starts straight into a drive slot.
  localparam logic [CntW-1:0] BlankLoad  = (BLANK_CYCLES > 0) ? CntW'(BLANK_CYCLES - 1)
                                                              : DriveLoad;
  localparam logic [IdxW-1:0] LastIdx    = IdxW'(DIGITS - 1);
  localparam state_e          ResetState = (BLANK_CYCLES > 0) ? StBlank : StDrive;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [8*DIGITS-1:0]   front_q, front_d;
  logic [8*DIGITS-1:0]   pending_q;
  logic                  pending_full_q;

  logic                  timer_load;
  logic [CntW-1:0]       timer_value;
  logic                  timer_tc, timer_tc_next;

  logic                  scan_end, swap, transfer;
  logic [7:0]            leds_d;
  logic [DIGITS-1:0]     control_d;
  logic                  done_d;

  digit_timer #(
    .Width      (CntW),
    .ResetValue (BlankLoad)
  ) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .tc         (timer_tc),
    .tc_next    (timer_tc_next)
  );

  assign transfer        = bus.frame_valid && !pending_full_q;
  assign swap            = scan_end && pending_full_q;
  assign front_d         = swap ? pending_q : front_q;
  assign bus.frame_ready = !pending_full_q;

  // Scan sequencing: advance state, digit index and slot timer on terminal count.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    timer_load  = 1'b0;
    timer_value = DriveLoad;
    scan_end    = 1'b0;
    unique case (state_q)
      StBlank: begin
        if (timer_tc) begin
          state_d     = StDrive;
          timer_load  = 1'b1;
          timer_value = DriveLoad;
        end
      end
      StDrive: begin
        if (timer_tc) begin
          scan_end   = (idx_q == LastIdx);
          idx_d      = scan_end ? '0 : idx_q + 1'b1;
          timer_load = 1'b1;
          if (BLANK_CYCLES > 0) begin
            state_d     = StBlank;
            timer_value = BlankLoad;
          end else begin
            state_d     = StDrive;
            timer_value = DriveLoad;
          end
        end
      end
      default: ;
    endcase
  end

  // Output values for the coming cycle, derived from next state so they register cleanly.
  always_comb begin
    control_d = '1;
    leds_d    = SEG_OFF;
    if (state_d == StDrive) begin
      control_d = ~(DIGITS'(1) << idx_d);
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (idx_d == IdxW'(i)) begin
          leds_d = ~front_d[8*i +: 8];
        end
      end
    end
    done_d = (state_d == StDrive) && (idx_d == LastIdx) && timer_tc_next;
  end

  // State, frame buffers and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= ResetState;
      idx_q           <= '0;
      front_q         <= '0;
      pending_q       <= '0;
      pending_full_q  <= 1'b0;
      display_leds    <= SEG_OFF;
      display_control <= '1;
      frame_done      <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      front_q <= front_d;
      // A transfer needs an empty pending buffer, so it never coincides with a swap.
      if (transfer) begin
        pending_q      <= bus.frame_data;
        pending_full_q <= 1'b1;
      end else if (swap) begin
        pending_full_q <= 1'b0;
      end
      display_leds    <= leds_d;
      display_control <= control_d;
      frame_done      <= done_d;
    end
  end

endmodule

// File: tb/tb_display_mux.sv
// Directed bench for display_mux with a 4-cycle drive, 2-cycle blank (6-cycle slot, 48-cycle frame).
module tb_display_mux;
  import calc_display_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] display_leds;
  logic [7:0] display_control;
  logic       frame_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  display_mux_if #(.DIGITS(8)) bus ();

  display_mux #(
    .DIGITS       (8),
    .DIGIT_CYCLES (4),
    .BLANK_CYCLES (2)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .bus             (bus),
    .display_leds    (display_leds),
    .display_control (display_control),
    .frame_done      (frame_done)
  );

  always #5 clock = ~clock;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  // Expected select pattern at cycle c counted from reset release.
  function automatic logic [7:0] sched_ctrl(input int c);
    logic [7:0] one;
    one = 8'h01;
    if (c % 6 < 2) return 8'hFF;
    return ~(one << ((c / 6) % 8));
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    bus.frame_valid = 1'b0;
    bus.frame_data  = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (display_control !== 8'hFF) begin
        errors++; $display("FAIL reset_ctrl: got %h expected ff", display_control);
      end
      checks++;
      if (display_leds !== 8'hFF) begin
        errors++; $display("FAIL reset_leds: got %h expected ff", display_leds);
      end
      checks++;
      if (bus.frame_ready !== 1'b1) begin
        errors++; $display("FAIL reset_ready: got %b expected 1", bus.frame_ready);
      end
      checks++;
      if (frame_done !== 1'b0) begin
        errors++; $display("FAIL reset_done: got %b expected 0", frame_done);
      end
    end
    reset = 1'b0;
    cyc = 0;
    step();
    step();
    checks++;
    if (display_control !== 8'hFE || display_leds !== 8'hFF) begin
      errors++;
      $display("FAIL first_digit: got ctrl %h leds %h expected fe ff", display_control, display_leds);
    end
  endtask

  task automatic test_load();
    logic [7:0] leds_exp [8];
    leds_exp = '{8'hB0, 8'hA4, 8'hC0, 8'hF9, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    bus.frame_data  = {D_EMPTY, D_EMPTY, D_EMPTY, D_EMPTY, D_1, D_0, D_2, D_3};
    bus.frame_valid = 1'b1;
    step();
    bus.frame_valid = 1'b0;
    checks++;
    if (bus.frame_ready !== 1'b0) begin
      errors++; $display("FAIL load_ready_low: got %b expected 0", bus.frame_ready);
    end
    run_to(47);
    checks++;
    if (frame_done !== 1'b1) begin
      errors++; $display("FAIL load_done: got %b expected 1 at cycle 47", frame_done);
    end
    step();
    checks++;
    if (bus.frame_ready !== 1'b1) begin
      errors++; $display("FAIL load_ready_high: got %b expected 1", bus.frame_ready);
    end
    for (int d = 0; d < 8; d++) begin
      run_to(48 + 6 * d + 2);
      checks++;
      if (display_control !== sched_ctrl(cyc) || display_leds !== leds_exp[d]) begin
        errors++;
        $display("FAIL load_digit%0d: got ctrl %h leds %h expected ctrl %h leds %h",
                 d, display_control, display_leds, sched_ctrl(cyc), leds_exp[d]);
      end
    end
  endtask

  task automatic test_back_to_back();
    run_to(90);
    bus.frame_data  = {D_8, D_7, D_6, D_5, D_4, D_A, D_B, D_C};
    bus.frame_valid = 1'b1;
    step();
    bus.frame_data  = {D_MINUS, D_R, D_O, D_DOT, D_E, D_F, D_9, D_5};
    run_to(95);
    checks++;
    if (frame_done !== 1'b1 || bus.frame_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_boundary: got done %b ready %b expected 1 0", frame_done, bus.frame_ready);
    end
    step();
    checks++;
    if (bus.frame_ready !== 1'b1 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ready_after: got ready %b done %b expected 1 0",
               bus.frame_ready, frame_done);
    end
    step();
    bus.frame_valid = 1'b0;
    checks++;
    if (bus.frame_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_transfer: got ready %b expected 0", bus.frame_ready);
    end
    run_to(98);
    checks++;
    if (display_control !== 8'hFE || display_leds !== 8'hC6) begin
      errors++;
      $display("FAIL b2b_second_d0: got ctrl %h leds %h expected fe c6", display_control, display_leds);
    end
    run_to(140);
    checks++;
    if (display_control !== 8'h7F || display_leds !== 8'h80) begin
      errors++;
      $display("FAIL b2b_second_d7: got ctrl %h leds %h expected 7f 80", display_control, display_leds);
    end
    run_to(146);
    checks++;
    if (display_control !== 8'hFE || display_leds !== 8'h92) begin
      errors++;
      $display("FAIL b2b_third_d0: got ctrl %h leds %h expected fe 92", display_control, display_leds);
    end
  endtask

  task automatic test_blanking();
    int last_done;
    last_done = -1;
    run_to(192);
    while (cyc < 336) begin
      checks++;
      if (display_control !== sched_ctrl(cyc)) begin
        errors++;
        $display("FAIL blank_ctrl: cycle %0d got %h expected %h", cyc, display_control, sched_ctrl(cyc));
      end
      checks++;
      if ($countones(~display_control) > 1) begin
        errors++; $display("FAIL blank_onehot: cycle %0d got %h expected at most one low", cyc,
                           display_control);
      end
      if (cyc % 6 < 2) begin
        checks++;
        if (display_leds !== 8'hFF) begin
          errors++; $display("FAIL blank_leds: cycle %0d got %h expected ff", cyc, display_leds);
        end
      end
      checks++;
      if (frame_done !== (cyc % 48 == 47)) begin
        errors++;
        $display("FAIL blank_done: cycle %0d got %b expected %b", cyc, frame_done, (cyc % 48 == 47));
      end
      if (frame_done === 1'b1) begin
        if (last_done >= 0) begin
          checks++;
          if (cyc - last_done != 48) begin
            errors++; $display("FAIL done_period: got %0d expected 48", cyc - last_done);
          end
        end
        last_done = cyc;
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    run_to(336);
    bus.frame_data  = {D_1, D_2, D_3, D_4, D_5, D_6, D_7, D_8};
    bus.frame_valid = 1'b1;
    step();
    bus.frame_data  = {D_A, D_B, D_C, D_D, D_E, D_F, D_0, D_9};
    run_to(369);
    checks++;
    if (display_control !== 8'hDF || bus.frame_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_setup: got ctrl %h ready %b expected df 0", display_control, bus.frame_ready);
    end
    reset = 1'b1;
    step();
    checks++;
    if (display_control !== 8'hFF || display_leds !== 8'hFF || frame_done !== 1'b0 ||
        bus.frame_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_vals: got ctrl %h leds %h done %b ready %b expected ff ff 0 1",
               display_control, display_leds, frame_done, bus.frame_ready);
    end
    reset = 1'b0;
    bus.frame_valid = 1'b0;
    cyc = 0;
    while (cyc < 51) begin
      checks++;
      if (display_control !== sched_ctrl(cyc) || display_leds !== 8'hFF) begin
        errors++;
        $display("FAIL mid_scan: cycle %0d got ctrl %h leds %h expected ctrl %h leds ff",
                 cyc, display_control, display_leds, sched_ctrl(cyc));
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_back_to_back();
    test_blanking();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_mux.md
# display_mux

Time-multiplexed driver for the eight-digit seven-segment display on the calculator board: the transmitting end of the `display_leds` / `display_control` interface. It takes a complete 64-bit segment frame from the calculator core over a valid/ready handshake and double-buffers it. It then scans the frame out one digit at a time with active-low segment and digit-select lines. A blanking gap between digits prevents ghosting.

## Interface
- `DIGITS`, default 8: number of digits scanned.
- `DIGIT_CYCLES`, default 1024: clock cycles each digit is driven; must be ≥1.
- `BLANK_CYCLES`, default 16: all-off cycles before each digit; 0 removes the gap.
- `clock` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `frame_data` in 8*DIGITS: segment patterns, active-high. Byte i covers bits [8i+7:8i] and drives digit i; digit 0 is the rightmost. Within a byte, bit 7 is the dot and bits 6..0 are segments g..a.
- `frame_valid` in 1: `frame_data` is offered.
- `frame_ready` out 1: the pending buffer is empty and can accept a frame.
- `display_leds` out 8: segment lines, active-low.
- `display_control` out DIGITS: digit select, active-low one-hot; all ones means no digit is selected.
- `frame_done` out 1: one-cycle pulse at the end of every full scan.

## Operation
- Two buffers:
  - `front` is the frame being displayed.
  - `pending` is the last accepted frame, with a `pending_full` flag.
- `frame_ready` = !`pending_full`.
- A transfer happens when `frame_valid` && `frame_ready` at a clock edge. The data is written to `pending` and `pending_full` is set.
- State machine states: BLANK and DRIVE. Digit index `idx` runs 0..DIGITS-1; a cycle counter tracks time within each state.
- BLANK:
  - Outputs: `display_control` all ones, `display_leds` = 8'hFF.
  - Lasts BLANK_CYCLES cycles, then goes to DRIVE.
  - When BLANK_CYCLES = 0, the state is skipped entirely.
- DRIVE:
  - Outputs: `display_control` = ~(1<<`idx`), `display_leds` = ~`front`[8·`idx`+7 : 8·`idx`].
  - Lasts DIGIT_CYCLES cycles.
  - On its last cycle: if `idx` < DIGITS-1, increment `idx`; otherwise set `idx` to 0. Then go to BLANK.
- Boundary cycle (last DRIVE cycle of digit DIGITS-1):
  - `frame_done` is 1.
  - If `pending_full`, then `front` <= `pending` and `pending_full` is cleared at that edge.
- A transfer during the boundary cycle can only occur when `pending` was already empty. The new data lands in `pending` and is shown from the following boundary on.
- At most one digit-select bit is low in any cycle. Segment and select lines change on the same edge, and only at state entry.
- Reset values:
  - `front` = 0 (all blank), `pending` = 0, `pending_full` = 0, `frame_ready` = 1.
  - `idx` = 0, state = BLANK (DRIVE if BLANK_CYCLES = 0).
  - `display_control` all ones, `display_leds` = 8'hFF, `frame_done` = 0.
- Reset mid-operation:
  - At the next edge, all of the above values apply.
  - A pending frame is discarded and the displayed frame is cleared.
  - A transfer offered in the same cycle as reset is dropped.

## Timing
- All outputs are registered; no combinational path from `frame_valid` or `frame_data` to any output.
- `frame_ready` goes to 0 on the edge after a transfer and back to 1 on the edge after the boundary swap.
- Slot length = BLANK_CYCLES + DIGIT_CYCLES. Frame period = DIGITS × slot = 8320 cycles at the default parameters.
- After reset release, digit 0 is first selected at cycle BLANK_CYCLES.
- Latency from transfer to visibility:
  - The accepted frame is first driven on digit 0 in the DRIVE after the next boundary.
  - Worst case is one frame period plus BLANK_CYCLES plus 1 cycle.

## Structure
- Shared package `calc_display_pkg` holds:
  - the state enum;
  - the segment constants: D_0..D_9, D_A..D_F, D_DOT, D_R, D_O, D_MINUS, D_EMPTY;
  - SEG_OFF = 8'hFF.
- Sub-module `digit_timer`: a loadable down-counter with a terminal-count flag, sized $clog2 of max(DIGIT_CYCLES, BLANK_CYCLES)+1. It is shared by BLANK and DRIVE.

## Test plan
All scenarios use DIGIT_CYCLES = 4 and BLANK_CYCLES = 2, giving a 6-cycle slot and a 48-cycle frame.
- Reset: hold `reset` for 3 cycles, then release.
  - During reset: `display_control` = 8'hFF, `display_leds` = 8'hFF, `frame_ready` = 1, `frame_done` = 0.
  - Cycle 2 after release: `display_control` = 8'hFE and `display_leds` = 8'hFF (blank frame).
- Load {D_EMPTY×4, D_1, D_0, D_2, D_3}:
  - `frame_ready` = 0 on the next cycle.
  - After the boundary, digit 0 shows `display_control` = 8'hFE with `display_leds` = 8'hB0.
  - Digit 3 shows `display_control` = 8'hF7 with `display_leds` = 8'hF9.
  - Digits 4..7 show `display_leds` = 8'hFF.
- Back-pressure: keep `frame_valid` high with a second frame while `pending` is full.
  - The transfer occurs exactly one cycle after the `frame_done` pulse.
  - The second frame becomes visible only after the following boundary.
- Blanking and exclusivity: over 3 frames,
  - exactly 2 cycles of all-ones select and 8'hFF segments between every pair of slots;
  - never more than one `display_control` bit low;
  - `frame_done` is one cycle wide with exactly 48 cycles between pulses.
- Reset mid-frame: assert `reset` during the digit-5 DRIVE with `pending` full and `frame_valid` high.
  - Next cycle: outputs at reset values and `frame_ready` = 1.
  - The following scan is all 8'hFF, with `idx` restarting at 0.
